vga_bus_pipe: RTL

//  Parametrised N-stage pipeline for the VGA timing bundle (h/v count, sync, blank) plus NCH parallel
//  RGB layers. Keeps all layers cycle-aligned with timing, adds frame/line start pulses, a frame

---
 rtl/vga_bus_pipe_pkg.sv | 24 ++
 rtl/vga_bus_pipe_delay_line.sv | 30 +++
 rtl/vga_bus_pipe.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/vga_bus_pipe_pkg.sv
// Shared types for the VGA timing pipeline: default widths and the packed timing bundle.
package vga_bus_pipe_pkg;

    localparam int unsigned VGA_CNT_W = 11;
    localparam int unsigned VGA_RGB_W = 12;

    typedef struct packed {
        logic [VGA_CNT_W-1:0] vcount;
        logic                 vsync;
        logic                 vblnk;
        logic [VGA_CNT_W-1:0] hcount;
        logic                 hsync;
        logic                 hblnk;
    } vga_tim_t;

    localparam int unsigned VGA_TIM_W = $bits(vga_tim_t);

    // Idle timing: both blanks asserted, everything else low.
    localparam vga_tim_t VGA_TIM_RST = '{
        vcount: '0, vsync: 1'b0, vblnk: 1'b1,
        hcount: '0, hsync: 1'b0, hblnk: 1'b1
    };

endpackage

// File: rtl/vga_bus_pipe_delay_line.sv
// Generic fixed-latency shift register with synchronous reset to a constant.
module vga_delay_line #(
    parameter int unsigned W       = 1,
    parameter int unsigned DEPTH   = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage[i] <= RST_VAL;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_bus_pipe.sv
// DEPTH-stage pipeline for VGA timing plus NCH RGB layers, with SOF/SOL pulses,
// a frame counter and a layer select that only switches on the start-of-frame pixel.
module vga_bus_pipe
    import vga_bus_pipe_pkg::*;
#(
    parameter int unsigned  CNT_W  = VGA_CNT_W,
    parameter int unsigned  RGB_W  = VGA_RGB_W,
    parameter int unsigned  NCH    = 2,
    parameter int unsigned  DEPTH  = 2,
    parameter int unsigned  FCNT_W = 8,
    localparam int unsigned SEL_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CNT_W-1:0]     in_hcount,
    input  logic [CNT_W-1:0]     in_vcount,
    input  logic                 in_hsync,
    input  logic                 in_vsync,
    input  logic                 in_hblnk,
    input  logic                 in_vblnk,
    input  logic [NCH*RGB_W-1:0] in_rgb,
    input  logic [SEL_W-1:0]     in_sel,
    output logic [CNT_W-1:0]     out_hcount,
    output logic [CNT_W-1:0]     out_vcount,
    output logic                 out_hsync,
    output logic                 out_vsync,
    output logic                 out_hblnk,
    output logic                 out_vblnk,
    output logic [NCH*RGB_W-1:0] out_rgb,
    output logic [RGB_W-1:0]     out_rgb_mux,
    output logic                 out_valid,
    output logic                 out_sof,
    output logic                 out_sol,
    output logic [FCNT_W-1:0]    frame_cnt,
    output logic                 sel_err
);

    localparam int unsigned FILL_W = $clog2(DEPTH + 1);

    if (DEPTH < 1 || DEPTH > 32) begin : g_depth_chk
        $error("vga_bus_pipe: DEPTH must be in 1..32");
    end
    if (NCH < 1 || NCH > 8) begin : g_nch_chk
        $error("vga_bus_pipe: NCH must be in 1..8");
    end
    if (CNT_W != VGA_CNT_W) begin : g_cnt_chk
        $error("vga_bus_pipe: CNT_W must match the packed timing bundle width");
    end

    vga_tim_t            tim_in;
    vga_tim_t            tim_out;
    logic [CNT_W-1:0]    prev_h;
    logic                first;
    logic                sol_in_c;
    logic                sof_in_c;
    logic [FILL_W-1:0]   fill;
    logic [SEL_W-1:0]    sel_pending;
    logic [SEL_W-1:0]    sel_active;
    logic [SEL_W-1:0]    sel_eff_c;
    logic                sel_ok_c;

    assign tim_in = '{vcount: in_vcount, vsync: in_vsync, vblnk: in_vblnk,
                      hcount: in_hcount, hsync: in_hsync, hblnk: in_hblnk};

    vga_delay_line #(.W(VGA_TIM_W), .DEPTH(DEPTH), .RST_VAL(VGA_TIM_RST)) u_tim (
        .clk (clk),
        .rst (rst),
        .d   (tim_in),
        .q   (tim_out)
    );

    vga_delay_line #(.W(NCH*RGB_W), .DEPTH(DEPTH), .RST_VAL('0)) u_rgb (
        .clk (clk),
        .rst (rst),
        .d   (in_rgb),
        .q   (out_rgb)
    );

    // Line/frame starts are detected on the input side and travel with their sample,
    // so the pulses land in the same cycle as the matching output counts.
    assign sol_in_c = (in_hcount == '0) && ((prev_h != '0) || first);
    assign sof_in_c = sol_in_c && (in_vcount == '0);

    vga_delay_line #(.W(2), .DEPTH(DEPTH), .RST_VAL(2'b00)) u_pulse (
        .clk (clk),
        .rst (rst),
        .d   ({sof_in_c, sol_in_c}),
        .q   ({out_sof, out_sol})
    );

    assign out_hcount = tim_out.hcount;
    assign out_vcount = tim_out.vcount;
    assign out_hsync  = tim_out.hsync;
    assign out_vsync  = tim_out.vsync;
    assign out_hblnk  = tim_out.hblnk;
    assign out_vblnk  = tim_out.vblnk;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_h      <= '0;
            first       <= 1'b1;
            sel_pending <= '0;
        end else begin
            prev_h      <= in_hcount;
            first       <= 1'b0;
            sel_pending <= in_sel;
        end
    end

    // Fill tracking: valid rises together with the first real sample at the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill      <= '0;
            out_valid <= 1'b0;
        end else if (!out_valid) begin
            fill <= fill + FILL_W'(1);
            if (fill == FILL_W'(DEPTH - 1)) begin
                out_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (out_sof) begin
            frame_cnt <= frame_cnt + FCNT_W'(1);
        end
    end

    // Select only changes on the SOF pixel; out-of-range requests are dropped there.
    assign sel_ok_c    = (NCH > 1) && (32'(sel_pending) < NCH);
    assign sel_eff_c   = (out_sof && sel_ok_c) ? sel_pending : sel_active;
    assign sel_err     = out_sof && !sel_ok_c && (NCH > 1);
    assign out_rgb_mux = out_rgb[RGB_W*32'(sel_eff_c) +: RGB_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_active <= '0;
        end else begin
            sel_active <= sel_eff_c;
        end
    end

endmodule
